// File: rtl/brisc_pkg.sv
// Shared helpers and mode encodings for the arbitrated output-register merge.
package brisc_pkg;

   localparam logic MODE_RR    = 1'b0;
   localparam logic MODE_FIXED = 1'b1;

   function automatic int unsigned CLOG2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(n)) r++;
      return r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin / fixed-priority picker with one-hot and encoded grant.
module rr_pick
   import brisc_pkg::*;
#(
   parameter int unsigned NCH = 4
) (
   input  logic [NCH-1:0]          req,
   input  logic [CLOG2(NCH)-1:0]   ptr,
   input  logic                    fixed,
   output logic [NCH-1:0]          gnt,
   output logic [CLOG2(NCH)-1:0]   idx,
   output logic                    any
);

   localparam int unsigned CW = CLOG2(NCH);

   logic [CW-1:0] start;
   logic [CW:0]   pos;
   logic [CW-1:0] sel;

   // Scan NCH slots from the start point, wrapping at NCH rather than 2^CW.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      any   = 1'b0;
      pos   = '0;
      sel   = '0;
      start = (fixed == MODE_FIXED) ? '0 : ptr;
      for (int unsigned k = 0; k < NCH; k++) begin
         pos = {1'b0, start} + (CW+1)'(k);
         if (pos >= (CW+1)'(NCH)) pos = pos - (CW+1)'(NCH);
         sel = pos[CW-1:0];
         if (!any && req[sel]) begin
            any      = 1'b1;
            gnt[sel] = 1'b1;
            idx      = sel;
         end
      end
   end

endmodule

// File: rtl/mux_arb_reg.sv
// N:1 arbitrated merge into a registered, back-pressurable valid/ready output stage.
module mux_arb_reg
   import brisc_pkg::*;
#(
   parameter int unsigned DW  = 32,
   parameter int unsigned NCH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    mode_fixed,
   input  logic [NCH-1:0]          in_valid,
   input  logic [NCH*DW-1:0]       in_data,
   output logic [NCH-1:0]          in_ready,
   output logic                    out_valid,
   output logic [DW-1:0]           out_data,
   output logic [CLOG2(NCH)-1:0]   out_chan,
   input  logic                    out_ready
);

   localparam int unsigned CW = CLOG2(NCH);

   logic [CW-1:0]  ptr;
   logic [NCH-1:0] gnt;
   logic [CW-1:0]  idx;
   logic           any;
   logic           load_en;
   logic [DW-1:0]  mux_data;

   rr_pick #(.NCH(NCH)) u_pick (
      .req   (in_valid),
      .ptr   (ptr),
      .fixed (mode_fixed),
      .gnt   (gnt),
      .idx   (idx),
      .any   (any)
   );

   // Output register is free when empty or draining this cycle.
   assign load_en  = !out_valid | out_ready;
   assign in_ready = gnt & {NCH{load_en}};

   always_comb begin
      mux_data = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         mux_data = mux_data | (in_data[i*DW +: DW] & {DW{gnt[i]}});
      end
   end

   // Pointer advances past every winner, in both modes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         ptr       <= '0;
      end else if (load_en) begin
         if (any) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_chan  <= idx;
            ptr       <= (idx == CW'(NCH-1)) ? '0 : idx + CW'(1);
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed bench for mux_arb_reg: 4-channel and 3-channel instances with hand-computed expectations.
module tb_mux_arb_reg;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   // 4-channel, 32-bit instance
   logic        a_mode;
   logic [3:0]  a_in_valid;
   logic [127:0] a_in_data;
   logic [3:0]  a_in_ready;
   logic        a_out_valid;
   logic [31:0] a_out_data;
   logic [1:0]  a_out_chan;
   logic        a_out_ready;

   // 3-channel, 8-bit instance
   logic        b_mode;
   logic [2:0]  b_in_valid;
   logic [23:0] b_in_data;
   logic [2:0]  b_in_ready;
   logic        b_out_valid;
   logic [7:0]  b_out_data;
   logic [1:0]  b_out_chan;
   logic        b_out_ready;

   mux_arb_reg #(.DW(32), .NCH(4)) u_dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode_fixed (a_mode),
      .in_valid   (a_in_valid),
      .in_data    (a_in_data),
      .in_ready   (a_in_ready),
      .out_valid  (a_out_valid),
      .out_data   (a_out_data),
      .out_chan   (a_out_chan),
      .out_ready  (a_out_ready)
   );

   mux_arb_reg #(.DW(8), .NCH(3)) u_dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode_fixed (b_mode),
      .in_valid   (b_in_valid),
      .in_data    (b_in_data),
      .in_ready   (b_in_ready),
      .out_valid  (b_out_valid),
      .out_data   (b_out_data),
      .out_chan   (b_out_chan),
      .out_ready  (b_out_ready)
   );

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n       = 1'b0;
      a_mode      = 1'b0;
      a_in_valid  = '0;
      a_in_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      a_out_ready = 1'b1;
      b_mode      = 1'b0;
      b_in_valid  = '0;
      b_in_data   = {8'h52, 8'h51, 8'h50};
      b_out_ready = 1'b1;
      #12;
      check("rst_valid", 64'(a_out_valid), 64'd0);
      check("rst_data",  64'(a_out_data),  64'd0);
      check("rst_chan",  64'(a_out_chan),  64'd0);
      #5 rst_n = 1'b1;
      tick();

      // Round-robin with all requesting: 0,1,2,3,0
      a_in_valid = 4'b1111;
      #1;
      check("rr_ready0", 64'(a_in_ready), 64'b0001);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("rr_valid", 64'(a_out_valid), 64'd1);
         check("rr_chan",  64'(a_out_chan),  64'(k % 4));
         check("rr_data",  64'(a_out_data),  64'(32'hA0 + (k % 4)));
      end

      // Fixed priority: ch1 beats ch3 until ch1 withdraws
      a_mode     = 1'b1;
      a_in_valid = 4'b1010;
      #1;
      check("fx_ready", 64'(a_in_ready), 64'b0010);
      for (int k = 0; k < 2; k++) begin
         tick();
         check("fx_chan",   64'(a_out_chan),    64'd1);
         check("fx_data",   64'(a_out_data),    64'hA1);
         check("fx_ready3", 64'(a_in_ready[3]), 64'd0);
      end
      a_in_valid = 4'b1000;
      #1;
      check("fx_ready_b", 64'(a_in_ready), 64'b1000);
      tick();
      check("fx_chan3", 64'(a_out_chan), 64'd3);
      check("fx_data3", 64'(a_out_data), 64'hA3);

      // Backpressure: hold ch3 beat for 3 cycles, then load without a bubble
      a_mode      = 1'b0;
      a_in_valid  = 4'b1111;
      a_out_ready = 1'b0;
      #1;
      check("bp_ready", 64'(a_in_ready), 64'b0000);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("bp_valid", 64'(a_out_valid), 64'd1);
         check("bp_data",  64'(a_out_data),  64'hA3);
         check("bp_ready", 64'(a_in_ready),  64'b0000);
      end
      a_out_ready = 1'b1;
      #1;
      check("bp_rel_ready", 64'(a_in_ready), 64'b0001);
      tick();
      check("bp_rel_valid", 64'(a_out_valid), 64'd1);
      check("bp_rel_chan",  64'(a_out_chan),  64'd0);
      check("bp_rel_data",  64'(a_out_data),  64'hA0);

      // Idle drain: single ch2 beat, then nothing
      a_in_valid = 4'b0100;
      tick();
      check("dr_chan",  64'(a_out_chan),  64'd2);
      check("dr_data",  64'(a_out_data),  64'hA2);
      a_in_valid = 4'b0000;
      tick();
      check("dr_valid", 64'(a_out_valid), 64'd0);
      check("dr_hold_chan", 64'(a_out_chan), 64'd2);
      check("dr_hold_data", 64'(a_out_data), 64'hA2);

      // Mid-stream reset: ptr=3 so ch3 loads, then async reset while held
      a_in_valid = 4'b1111;
      tick();
      check("mr_chan", 64'(a_out_chan), 64'd3);
      a_out_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("mr_valid", 64'(a_out_valid), 64'd0);
      check("mr_data",  64'(a_out_data),  64'd0);
      check("mr_chan0", 64'(a_out_chan),  64'd0);
      #3 rst_n = 1'b1;
      a_out_ready = 1'b1;
      #1;
      check("mr_ready", 64'(a_in_ready), 64'b0001);
      tick();
      check("mr_first", 64'(a_out_chan), 64'd0);
      a_in_valid = '0;

      // Three channels: pointer wraps at 3
      b_in_valid = 3'b100;
      tick();
      check("w_chan2", 64'(b_out_chan), 64'd2);
      check("w_data2", 64'(b_out_data), 64'h52);
      b_in_valid = 3'b111;
      #1;
      check("w_ready", 64'(b_in_ready), 64'b001);
      tick();
      check("w_chan0", 64'(b_out_chan), 64'd0);
      b_in_valid = 3'b001;
      tick();
      check("w_again",  64'(b_out_chan), 64'd0);
      check("w_data0",  64'(b_out_data), 64'h50);
      check("w_valid",  64'(b_out_valid), 64'd1);
      b_in_valid = '0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_arb_reg.md
Name: mux_arb_reg

Overview:
- Parametrised successor to the datapath N:1 selector: NCH input channels, DW-bit data, registered output with valid/ready handshake.
- Selection is no longer a static select bus. An internal arbiter picks one requesting channel per accepted beat, using round-robin or fixed-priority mode.
- Used wherever several producers (register-file write sources, bus masters, memory requesters) share one consumer path and need a registered, back-pressurable merge.

Parameters:
- DW, 32, data width per channel
- NCH, 4, number of input channels (2..16)
- CW, $clog2(NCH), channel-index width (derived; must not be overridden)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mode_fixed  in  1  1 = fixed priority (channel 0 highest); 0 = round-robin
- in_valid  in  NCH  per-channel request/valid
- in_data  in  NCH*DW  channel i occupies bits [i*DW +: DW]
- in_ready  out  NCH  per-channel accept; at most one bit high per cycle
- out_valid  out  1  output register holds a beat
- out_data  out  DW  registered selected data
- out_chan  out  CW  index of the channel that supplied out_data
- out_ready  in  1  consumer accept

Behaviour:
- Reset (async assert, sync-safe deassert):
  - out_valid=0, out_data=0, out_chan=0, round-robin pointer ptr=0.
  - in_ready is combinational and is therefore 0 while out_valid=0 only if no in_valid is set; see load_en below.
- load_en = !out_valid | out_ready. The output register accepts a new beat when it is empty or being drained this cycle (full-throughput pipelining, no bubble).
- Grant (combinational, from in_valid):
  - fixed mode: lowest-index asserted in_valid.
  - round-robin mode: first asserted in_valid searching ptr, ptr+1, …, NCH-1, 0, …, ptr-1 (wrap-around modulo NCH).
  - No request means no grant.
- in_ready[i] = grant[i] & load_en. A transfer on channel i occurs when in_valid[i] & in_ready[i].
- On a transfer:
  - out_data <= selected in_data, out_chan <= i, out_valid <= 1.
  - ptr <= (i+1) mod NCH. The pointer updates in both modes, so switching to round-robin resumes after the last winner.
- Drain without new transfer (out_valid & out_ready, no grant): out_valid <= 0. out_data and out_chan hold their last values.
- Stall (out_valid & !out_ready): out_valid, out_data and out_chan hold; all in_ready=0.
- Latency: 1 cycle from input transfer to out_valid. Sustained throughput is 1 beat/cycle.
- Simultaneous drain and load in the same cycle: the new beat replaces the old one and out_valid stays 1.
- mode_fixed may change any cycle and takes effect on that cycle's grant. No beat is lost or duplicated.
- Reset asserted mid-transfer: the held beat is discarded, ptr returns to 0, and out_valid drops immediately (asynchronously).
- Inputs must keep in_valid and in_data stable until accepted (standard valid/ready). The block does not itself check this.
- NCH not a power of two: ptr wraps at NCH, never at 2^CW. Indices >= NCH are never granted.

Decomposition:
- Shared package (brisc_pkg): CLOG2 helper function and mode encoding constants MODE_RR=1'b0 and MODE_FIXED=1'b1.
- One sub-module, rr_pick: combinational NCH-wide round-robin/fixed picker.
  - Inputs: req[NCH], ptr[CW], fixed.
  - Outputs: one-hot gnt[NCH], idx[CW], any.
- mux_arb_reg instantiates rr_pick and holds ptr and the output register. The data mux is an AND-OR over one-hot gnt.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_chan=0 asynchronously; after release, first grant with all requesting in round-robin mode is channel 0.
- Round-robin fairness: NCH=4, in_valid=4'b1111 held, out_ready=1, data ch i = 32'hA0+i -> out_chan sequence 0,1,2,3,0,… one per cycle; out_data 32'hA0,A1,A2,A3.
- Fixed priority: mode_fixed=1, in_valid=4'b1010 -> ch1 wins every cycle; ch3 in_ready stays 0 until in_valid[1] drops, then ch3 granted next cycle.
- Backpressure: out_ready=0 for 3 cycles with one beat held -> out_data stable, in_ready=4'b0000; out_ready=1 -> next beat loaded the same cycle, out_valid never drops.
- Wrap and sparse: NCH=3 (CW=2), ptr after ch2 grant = 0 (not 3); in_valid=3'b001 after ch0 grant -> ch0 granted again.
- Idle drain: single beat on ch2 then no requests, out_ready=1 -> out_valid high one cycle then 0; out_chan stays 2.
